module_3: RTL

//  Downstream dataflow stage of module_2 in the Ping_pong toy: consumes ping-pong buffer D
//  (squares written by module_2), writes running prefix sums to buffer E and reports the

---
 rtl/module_3.sv | 131 +++++++++++++
 1 files changed

// File: rtl/module_3.sv
// rtl/module_3.sv - prefix-sum dataflow stage: reads D, writes running sums to E, reports total
module module_3 #(
  parameter int N  = 5,
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          ap_start,
  output logic          ap_done,
  input  logic          ap_continue,
  output logic          ap_idle,
  output logic          ap_ready,
  output logic [AW-1:0] D_address0,
  output logic          D_ce0,
  input  logic [DW-1:0] D_q0,
  output logic [AW-1:0] E_address0,
  output logic          E_ce0,
  output logic          E_we0,
  output logic [DW-1:0] E_d0,
  output logic [DW-1:0] sum_out,
  output logic          sum_out_ap_vld
);

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_RD   = 5'b00010,
    S_LAT  = 5'b00100,
    S_ACC  = 5'b01000,
    S_WR   = 5'b10000
  } state_t;

  // loop bound in address width; the index runs 0..N inclusive before finishing
  localparam logic [AW-1:0] LAST = AW'(N);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_inc;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] d_reg;
  logic [DW-1:0] acc;
  logic          done_reg;

  logic          idx_last;
  logic          start_ok;
  logic          done_now;

  assign idx_last = (idx == LAST);
  assign start_ok = (state == S_IDLE) && ap_start && !done_reg;
  assign done_now = (state == S_RD) && idx_last;

  // state register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state: one element takes RD -> LAT -> ACC -> WR, finishing from RD
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_ok) state_next = S_RD;
      S_RD:    state_next = idx_last ? S_IDLE : S_LAT;
      S_LAT:   state_next = S_ACC;
      S_ACC:   state_next = S_WR;
      S_WR:    state_next = S_RD;
      default: state_next = S_IDLE;
    endcase
  end

  // datapath: loop index, write address, read data capture and running sum
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      idx     <= '0;
      idx_inc <= '0;
      e_addr  <= '0;
      d_reg   <= '0;
      acc     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            idx <= '0;
            acc <= '0;
          end
        end
        S_RD: begin
          if (!idx_last) begin
            e_addr  <= idx;
            idx_inc <= idx + AW'(1);
          end
        end
        S_LAT:   d_reg <= D_q0;
        S_ACC:   acc   <= acc + d_reg;
        S_WR:    idx   <= idx_inc;
        default: ;
      endcase
    end
  end

  // sticky done held until downstream acknowledges; an ack in the done cycle suppresses it
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      done_reg <= 1'b0;
    end else if (ap_continue) begin
      done_reg <= 1'b0;
    end else if (done_now) begin
      done_reg <= 1'b1;
    end
  end

  // handshake and memory port outputs decoded from the current state
  always_comb begin
    ap_done        = done_now | done_reg;
    ap_ready       = done_now;
    ap_idle        = (state == S_IDLE) && !ap_start;
    sum_out        = acc;
    sum_out_ap_vld = done_now;
    D_address0     = idx;
    D_ce0          = (state == S_RD) && !idx_last;
    E_address0     = e_addr;
    E_d0           = acc;
    E_ce0          = (state == S_WR);
    E_we0          = (state == S_WR);
  end

endmodule
